nwc_ntt_scheduler: RTL and testbench

- Address/control sequencer for the forward negacyclic NTT.
- Sits directly upstream of the 2-cycle butterfly unit.
- Per stage, it issues butterfly pair read addresses to the dual-port coefficient RAM and the twiddle ROM address.
- Delays those addresses to produce write-back addresses aligned with butterfly outputs, and drains the pipeline between stages to prevent read-after-write hazards.

---
 rtl/nwc_ntt_scheduler.sv | 153 +++++++++++++++
 tb/tb_nwc_ntt_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nwc_ntt_scheduler.sv
// Address/control sequencer for the forward negacyclic NTT: issues butterfly pair reads per stage,
// delays them into aligned write-back addresses, and drains the pipeline between stages.
module nwc_ntt_scheduler #(
    parameter int N      = 16,
    parameter int LOG_N  = 4,
    parameter int RD_LAT = 1,
    parameter int BU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG_N-1:0] stage,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] tw_addr,
    output logic             bu_valid,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int PL   = RD_LAT + BU_LAT;
    localparam int HALF = N / 2;
    localparam int PW   = LOG_N - 1;
    localparam int DW   = (PL > 1) ? $clog2(PL) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t          state, state_n;
    logic [LOG_N-1:0] s, s_n;
    logic [PW-1:0]    p, p_n;
    logic [DW-1:0]    d, d_n;
    logic             busy_n;

    logic [LOG_N-1:0] pw, t, g, a_n, b_n, tw_n;

    logic [PL-1:0]    v_pipe;
    logic [LOG_N-1:0] a_pipe [PL];
    logic [LOG_N-1:0] b_pipe [PL];

    always_comb begin
        state_n = state;
        s_n     = s;
        p_n     = p;
        d_n     = d;
        unique case (state)
            IDLE: begin
                s_n = '0;
                p_n = '0;
                if (start) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (p == PW'(HALF - 1)) begin
                    state_n = DRAIN;
                    d_n     = '0;
                end else begin
                    p_n = p + PW'(1);
                end
            end
            DRAIN: begin
                // Hold the stage index while its writes are still in flight.
                if (d == DW'(PL - 1)) begin
                    if (s != LOG_N'(LOG_N - 1)) begin
                        state_n = ISSUE;
                        s_n     = s + LOG_N'(1);
                        p_n     = '0;
                    end else begin
                        state_n = FINISH;
                    end
                end else begin
                    d_n = d + DW'(1);
                end
            end
            FINISH: begin
                state_n = IDLE;
                s_n     = '0;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == ISSUE) || (state_n == DRAIN);
    end

    // Pair p in stage s: group g = p / t, offset j = p mod t, both butterflies share twiddle m + g.
    always_comb begin
        pw   = {1'b0, p_n};
        t    = LOG_N'(N >> (int'(s_n) + 1));
        g    = pw >> (LOG_N - 1 - int'(s_n));
        a_n  = (g << (LOG_N - int'(s_n))) | (pw & (t - LOG_N'(1)));
        b_n  = a_n + t;
        tw_n = LOG_N'(1 << int'(s_n)) + g;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            p         <= '0;
            d         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            p     <= p_n;
            d     <= d_n;
            busy  <= busy_n;
            done  <= (state_n == FINISH);
            stage <= busy_n ? s_n : '0;
            rd_en <= (state_n == ISSUE);
            if (state_n == ISSUE) begin
                rd_addr_a <= a_n;
                rd_addr_b <= b_n;
                tw_addr   <= tw_n;
            end
        end
    end

    // Read strobe and addresses ride a PL-deep line so writes land with the butterfly results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < PL; i++) begin
                a_pipe[i] <= '0;
                b_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= rd_en;
            a_pipe[0] <= rd_addr_a;
            b_pipe[0] <= rd_addr_b;
            for (int i = 1; i < PL; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
                b_pipe[i] <= b_pipe[i-1];
            end
        end
    end

    assign bu_valid  = v_pipe[RD_LAT-1];
    assign wr_en     = v_pipe[PL-1];
    assign wr_addr_a = a_pipe[PL-1];
    assign wr_addr_b = b_pipe[PL-1];

endmodule

// File: tb/tb_nwc_ntt_scheduler.sv
// Bench for nwc_ntt_scheduler: closed-form cycle model, scenario table, random starts/resets,
// and a butterfly scoreboard comparing RAM contents against a direct negacyclic NTT.
module tb_nwc_ntt_scheduler;

    localparam int N      = 16;
    localparam int LOG_N  = 4;
    localparam int RD_LAT = 1;
    localparam int BU_LAT = 2;
    localparam int PL     = RD_LAT + BU_LAT;
    localparam int HALF   = N / 2;
    localparam int L      = HALF + PL;
    localparam int RUN    = LOG_N * L;
    localparam longint Q  = 12289;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy, done, rd_en, bu_valid, wr_en;
    logic [LOG_N-1:0] stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

    always #5 clk = ~clk;

    nwc_ntt_scheduler #(.N(N), .LOG_N(LOG_N), .RD_LAT(RD_LAT), .BU_LAT(BU_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bu_valid(bu_valid), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected pair order straight from the textbook Cooley-Tukey loop nest.
    int pa [LOG_N*HALF];
    int pb [LOG_N*HALF];
    int pt [LOG_N*HALF];

    // mc = cycles since start accepted (0 = idle); done lands at RUN+1.
    int mc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst)                 mc <= 0;
        else if (mc == 0)        mc <= start ? 1 : 0;
        else if (mc == RUN + 1)  mc <= 0;
        else                     mc <= mc + 1;
    end

    function automatic bit rd_at(input int c);
        return (c >= 1) && (c <= RUN) && (((c - 1) % L) < HALF);
    endfunction

    function automatic int idx_of(input int c);
        return ((c - 1) / L) * HALF + ((c - 1) % L);
    endfunction

    function automatic longint modpow(input longint b, input longint e);
        longint r = 1, x = b % Q, k = e;
        while (k > 0) begin
            if (k[0]) r = (r * x) % Q;
            x = (x * x) % Q;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int brv(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    longint mem  [N];
    longint zeta [N];
    longint sbq  [$];
    bit     sb_en = 0;
    int     rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;

    task automatic sample();
        logic [31:0] ec, ac, ep, ap;
        int c;
        longint u, v, x, y;
        if (rst) return;
        c  = mc;
        ec = {23'b0, (c >= 1 && c <= RUN), (c == RUN + 1),
              ((c >= 1 && c <= RUN) ? 4'((c - 1) / L) : 4'd0),
              rd_at(c), rd_at(c - RD_LAT), rd_at(c - PL)};
        ac = {23'b0, busy, done, stage, rd_en, bu_valid, wr_en};
        chk("ctrl", ac, ec);
        if (rd_at(c)) begin
            ep = {20'b0, 4'(pa[idx_of(c)]), 4'(pb[idx_of(c)]), 4'(pt[idx_of(c)])};
            ap = {20'b0, rd_addr_a, rd_addr_b, tw_addr};
            chk("rd_pair", ap, ep);
        end
        if (rd_at(c - PL)) begin
            ep = {24'b0, 4'(pa[idx_of(c - PL)]), 4'(pb[idx_of(c - PL)])};
            ap = {24'b0, wr_addr_a, wr_addr_b};
            chk("wr_pair", ap, ep);
        end
        rd_cnt   += int'(rd_en);
        wr_cnt   += int'(wr_en);
        done_cnt += int'(done);
        busy_cnt += int'(busy);
        if (sb_en) begin
            if (wr_en && sbq.size() >= 2) begin
                x = sbq.pop_front();
                y = sbq.pop_front();
                mem[wr_addr_a] = x;
                mem[wr_addr_b] = y;
            end
            if (rd_en) begin
                u = mem[rd_addr_a];
                v = (mem[rd_addr_b] * zeta[tw_addr]) % Q;
                sbq.push_back((u + v) % Q);
                sbq.push_back((u - v + Q) % Q);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        #1;
    endtask

    typedef struct {
        string name;
        int    win;
        int    extra;
        int    rstc;
        bit    hold;
        bit    ntt;
        int    e_rd, e_wr, e_done, e_busy;
    } scn_t;

    scn_t   tbl [5];
    longint a0  [N];
    longint psi, ref_v;

    initial begin
        int i0;
        int b_rd, b_wr, b_dn, b_bs;

        for (int s = 0; s < LOG_N; s++) begin
            i0 = s * HALF;
            for (int i = 0; i < (1 << s); i++)
                for (int j = 0; j < (N >> (s + 1)); j++) begin
                    pa[i0] = 2 * i * (N >> (s + 1)) + j;
                    pb[i0] = pa[i0] + (N >> (s + 1));
                    pt[i0] = (1 << s) + i;
                    i0++;
                end
        end
        psi = 0;
        for (longint gg = 2; gg < Q && psi == 0; gg++)
            if (modpow(modpow(gg, (Q - 1) / (2 * N)), N) == Q - 1) psi = modpow(gg, (Q - 1) / (2 * N));
        for (int k = 0; k < N; k++) zeta[k] = modpow(psi, brv(k, LOG_N));

        tbl[0] = '{"normal",  50, -1, -1, 1'b0, 1'b1, 32, 32, 1, 44};
        tbl[1] = '{"extra",   50, 20, -1, 1'b0, 1'b0, 32, 32, 1, 44};
        tbl[2] = '{"abort",   25, -1, 17, 1'b0, 1'b0, 14, 11, 0, 17};
        tbl[3] = '{"restart", 50, -1, -1, 1'b0, 1'b0, 32, 32, 1, 44};
        tbl[4] = '{"hold",    95, -1, -1, 1'b1, 1'b0, 64, 64, 2, 88};

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_a", 32'(rd_addr_a), 0);
        chk("rst_rd_b", 32'(rd_addr_b), 0);
        chk("rst_tw", 32'(tw_addr), 0);
        chk("rst_bu_valid", 32'(bu_valid), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_a", 32'(wr_addr_a), 0);
        chk("rst_wr_b", 32'(wr_addr_b), 0);
        rst = 1'b0;
        repeat (10) tick();

        for (int k = 0; k < 5; k++) begin
            b_rd = rd_cnt; b_wr = wr_cnt; b_dn = done_cnt; b_bs = busy_cnt;
            if (tbl[k].ntt) begin
                for (int i = 0; i < N; i++) begin
                    a0[i]  = longint'($urandom_range(0, Q - 1));
                    mem[i] = a0[i];
                end
                sbq.delete();
                sb_en = 1'b1;
            end
            start = 1'b1;
            for (int cyc = 1; cyc <= tbl[k].win; cyc++) begin
                tick();
                start = (tbl[k].hold && cyc <= 46) || (cyc == tbl[k].extra);
                if (cyc == tbl[k].rstc) begin
                    rst = 1'b1;
                    #1;
                    chk({tbl[k].name, "_rst_now"}, {27'b0, busy, rd_en, wr_en, done, |stage}, 0);
                end else begin
                    rst = 1'b0;
                end
            end
            start = 1'b0;
            rst   = 1'b0;
            sb_en = 1'b0;
            chk({tbl[k].name, "_rd_cnt"}, rd_cnt - b_rd, tbl[k].e_rd);
            chk({tbl[k].name, "_wr_cnt"}, wr_cnt - b_wr, tbl[k].e_wr);
            chk({tbl[k].name, "_done_cnt"}, done_cnt - b_dn, tbl[k].e_done);
            chk({tbl[k].name, "_busy_cnt"}, busy_cnt - b_bs, tbl[k].e_busy);
            if (tbl[k].ntt) begin
                for (int kk = 0; kk < N; kk++) begin
                    ref_v = 0;
                    for (int j = 0; j < N; j++)
                        ref_v = (ref_v + a0[j] * modpow(psi, ((2 * brv(kk, LOG_N) + 1) * j) % (2 * N))) % Q;
                    chk("ntt_coef", 32'(mem[kk]), 32'(ref_v));
                end
            end
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            start = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (50) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
